mem_arbiter: RTL and testbench

//   Shares one unified memory bus between the core's instruction-fetch port and its data port.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_prio_sel.sv | 33 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory bus arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [31:0] opcode_t;
  typedef logic [3:0]  be_t;

  localparam be_t BeAll = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
    be_t   be;
  } bus_req_t;

endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// Winner select (data first, fetch forced after a run of data grants) and run counter update.
module arb_prio_sel #(
  parameter int unsigned MaxDataRun = 4
) (
  input  logic       arb_en,
  input  logic       if_valid,
  input  logic       d_req,
  input  logic       gnt,
  input  logic [3:0] run_cnt,
  output logic       if_win,
  output logic       d_win,
  output logic [3:0] run_cnt_nxt
);

  logic force_if;

  assign force_if = if_valid && (run_cnt == 4'(MaxDataRun));
  assign d_win    = arb_en && d_req && !force_if;
  assign if_win   = arb_en && if_valid && !d_win;

  // Run counter: cleared when fetch is idle or served, saturating count of data grants otherwise.
  always_comb begin
    run_cnt_nxt = run_cnt;
    if (!if_valid) begin
      run_cnt_nxt = '0;
    end else if (gnt && if_win) begin
      run_cnt_nxt = '0;
    end else if (gnt && d_win && (run_cnt != 4'(MaxDataRun))) begin
      run_cnt_nxt = run_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one request/grant/response memory bus between fetch and data ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MaxDataRun = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    if_valid,
  input  addr_t   if_addr,
  output logic    if_done,
  output opcode_t if_data,
  input  logic    d_re,
  input  logic    d_we,
  input  addr_t   d_addr,
  input  data_t   d_w_data,
  input  be_t     d_w_mask,
  output logic    d_done,
  output data_t   d_r_data,
  output logic    bus_req,
  output logic    bus_we,
  output addr_t   bus_addr,
  output data_t   bus_wdata,
  output be_t     bus_be,
  input  logic    bus_gnt,
  input  logic    bus_rvalid,
  input  data_t   bus_rdata
);

  arb_state_e state, state_nxt;
  logic [3:0] run_cnt, run_cnt_nxt;
  logic       arb_en, d_req, if_win, d_win;
  bus_req_t   sel;

  // Arbitration only happens in IDLE and never while reset is asserted.
  assign arb_en = (state == IDLE) && !rst;
  assign d_req  = d_re | d_we;

  arb_prio_sel #(
    .MaxDataRun(MaxDataRun)
  ) u_prio_sel (
    .arb_en      (arb_en),
    .if_valid    (if_valid),
    .d_req       (d_req),
    .gnt         (bus_gnt),
    .run_cnt     (run_cnt),
    .if_win      (if_win),
    .d_win       (d_win),
    .run_cnt_nxt (run_cnt_nxt)
  );

  // Request mux: drive only the current winner's fields, zero otherwise.
  always_comb begin
    sel = '0;
    if (d_win) begin
      sel.we    = d_we;
      sel.addr  = d_addr;
      sel.wdata = d_we ? d_w_data : '0;
      sel.be    = d_we ? d_w_mask : BeAll;
    end else if (if_win) begin
      sel.addr  = if_addr;
      sel.be    = BeAll;
    end
  end

  assign bus_req   = d_win | if_win;
  assign bus_we    = sel.we;
  assign bus_addr  = sel.addr;
  assign bus_wdata = sel.wdata;
  assign bus_be    = sel.be;

  // Next state and response routing; responses are dropped while reset is asserted.
  always_comb begin
    state_nxt = state;
    if_done   = 1'b0;
    d_done    = 1'b0;
    if_data   = '0;
    d_r_data  = '0;
    case (state)
      IDLE: begin
        if (bus_gnt && d_win) begin
          state_nxt = WAIT_D;
        end else if (bus_gnt && if_win) begin
          state_nxt = WAIT_IF;
        end
      end
      WAIT_IF: begin
        if (bus_rvalid) begin
          if_done   = !rst;
          if_data   = rst ? '0 : bus_rdata;
          state_nxt = IDLE;
        end
      end
      WAIT_D: begin
        if (bus_rvalid) begin
          d_done    = !rst;
          d_r_data  = rst ? '0 : bus_rdata;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and run counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_cnt_nxt;
    end
  end

  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE) |-> !bus_rvalid);
  a_if_held: assert property (@(posedge clk) disable iff (rst)
    (state == WAIT_IF) |-> if_valid);
  a_d_held: assert property (@(posedge clk) disable iff (rst)
    (state == WAIT_D) |-> d_req);
  a_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !(d_re && d_we));
  a_done_excl: assert property (@(posedge clk)
    !(if_done && d_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of the fetch/data memory arbiter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic    clk;
  logic    rst;
  logic    if_valid;
  addr_t   if_addr;
  logic    if_done;
  opcode_t if_data;
  logic    d_re, d_we;
  addr_t   d_addr;
  data_t   d_w_data;
  be_t     d_w_mask;
  logic    d_done;
  data_t   d_r_data;
  logic    bus_req, bus_we;
  addr_t   bus_addr;
  data_t   bus_wdata;
  be_t     bus_be;
  logic    bus_gnt, bus_rvalid;
  data_t   bus_rdata;

  logic    m_gnt, m_rvalid;
  data_t   m_rdata;

  logic        auto_mode = 1'b0;
  logic        mem_busy  = 1'b0;
  int unsigned gnt_dly   = 0;
  int unsigned rv_dly    = 0;
  data_t       mem_rdata = '0;
  logic        a_gnt, a_rvalid;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .MaxDataRun(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_data    (if_data),
    .d_re       (d_re),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_w_data   (d_w_data),
    .d_w_mask   (d_w_mask),
    .d_done     (d_done),
    .d_r_data   (d_r_data),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic data_t mem_f(input addr_t a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // Randomised memory: grant after 0..5 requesting cycles, respond 0..5 cycles after grant.
  assign a_gnt    = auto_mode && !mem_busy && (gnt_dly == 0);
  assign a_rvalid = auto_mode && mem_busy && (rv_dly == 0);
  assign bus_gnt    = auto_mode ? a_gnt    : m_gnt;
  assign bus_rvalid = auto_mode ? a_rvalid : m_rvalid;
  assign bus_rdata  = auto_mode ? (a_rvalid ? mem_rdata : '0) : m_rdata;

  always @(posedge clk) begin
    if (auto_mode) begin
      if (!mem_busy) begin
        if (bus_req && a_gnt) begin
          mem_busy  <= 1'b1;
          rv_dly    <= $urandom_range(0, 5);
          mem_rdata <= mem_f(bus_addr);
        end else if (bus_req && gnt_dly != 0) begin
          gnt_dly <= gnt_dly - 1;
        end
      end else if (rv_dly == 0) begin
        mem_busy <= 1'b0;
        gnt_dly  <= $urandom_range(0, 5);
      end else begin
        rv_dly <= rv_dly - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem(input logic g, input logic rv, input data_t rd);
    m_gnt    = g;
    m_rvalid = rv;
    m_rdata  = rd;
  endtask

  task automatic clear_reqs();
    if_valid = 1'b0; if_addr = '0;
    d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_w_data = '0; d_w_mask = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned kind;
    int          cyc;
    logic        if_pend, d_pend, d_is_rd;
    addr_t       ia, da;

    rst = 1'b1;
    clear_reqs();
    mem(0, 0, '0);
    repeat (2) @(negedge clk);

    // Requests and grant during reset must produce no bus activity.
    @(negedge clk);
    if_valid = 1; if_addr = 32'h100; d_re = 1; d_addr = 32'h2000; mem(1, 0, '0);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_dones", {if_done, d_done}, 0);

    @(negedge clk);
    rst = 0; clear_reqs(); mem(0, 0, '0);
    #1;
    chk("post_rst_bus_req", bus_req, 0);
    chk("post_rst_bus_fields", {bus_we, bus_addr, bus_wdata, bus_be}, 0);
    chk("post_rst_data", {if_data, d_r_data}, 0);

    // 1: fetch only
    @(negedge clk);
    if_valid = 1; if_addr = 32'h100; mem(1, 0, '0);
    #1;
    chk("t1_req", bus_req, 1);
    chk("t1_addr", bus_addr, 32'h100);
    chk("t1_be", bus_be, 4'hF);
    chk("t1_we", bus_we, 0);
    @(negedge clk);
    mem(0, 1, 32'h0000_0013);
    #1;
    chk("t1_req_wait", bus_req, 0);
    chk("t1_if_done", if_done, 1);
    chk("t1_if_data", if_data, 32'h0000_0013);
    chk("t1_d_done", d_done, 0);
    @(negedge clk);
    clear_reqs(); mem(0, 0, '0);
    #1;
    chk("t1_done_pulse", if_done, 0);

    // 2: simultaneous fetch and data read
    @(negedge clk);
    if_valid = 1; if_addr = 32'h104; d_re = 1; d_addr = 32'h2000; mem(1, 0, '0);
    #1;
    chk("t2_addr", bus_addr, 32'h2000);
    chk("t2_we_be", {bus_we, bus_be}, 5'b0_1111);
    @(negedge clk);
    mem(0, 1, 32'hDEAD_BEEF);
    #1;
    chk("t2_d_done", {if_done, d_done}, 2'b01);
    chk("t2_d_r_data", d_r_data, 32'hDEAD_BEEF);
    @(negedge clk);
    d_re = 0; d_addr = '0; mem(1, 0, '0);
    #1;
    chk("t2_fetch_req", {bus_req, bus_we}, 2'b10);
    chk("t2_fetch_addr", bus_addr, 32'h104);
    @(negedge clk);
    mem(0, 1, 32'h0050_0093);
    #1;
    chk("t2_if_done", {if_done, d_done}, 2'b10);
    chk("t2_if_data", if_data, 32'h0050_0093);
    @(negedge clk);
    clear_reqs(); mem(0, 0, '0);

    // 3: starvation guard with continuous data writes
    @(negedge clk);
    if_valid = 1; if_addr = 32'h200;
    d_we = 1; d_addr = 32'h3000; d_w_data = 32'h1122_3344; d_w_mask = 4'b1100;
    mem(0, 0, '0);
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      mem(1, 0, '0);
      #1;
      if (r == 4) begin
        chk("t3_fetch_addr", bus_addr, 32'h200);
        chk("t3_fetch_fields", {bus_we, bus_wdata, bus_be}, {1'b0, 32'h0, 4'hF});
      end else begin
        chk("t3_data_addr", bus_addr, 32'h3000);
        chk("t3_data_fields", {bus_we, bus_wdata, bus_be}, {1'b1, 32'h1122_3344, 4'b1100});
      end
      @(negedge clk);
      mem(0, 1, (r == 4) ? 32'h13 : 32'h0);
      #1;
      chk("t3_dones", {if_done, d_done}, (r == 4) ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    clear_reqs(); mem(0, 0, '0);

    // 4: grant withheld, data arrives and takes over the request
    @(negedge clk);
    if_valid = 1; if_addr = 32'h300; mem(0, 0, '0);
    #1;
    chk("t4_c0_req", bus_req, 1);
    chk("t4_c0_addr", bus_addr, 32'h300);
    @(negedge clk);
    d_we = 1; d_addr = 32'h4000; d_w_data = 32'hCAFE_F00D; d_w_mask = 4'b0011;
    #1;
    chk("t4_c1_addr", bus_addr, 32'h4000);
    chk("t4_c1_we_be", {bus_we, bus_be}, 5'b1_0011);
    @(negedge clk);
    #1;
    chk("t4_c2_held", {bus_req, bus_we, bus_wdata}, {2'b11, 32'hCAFE_F00D});
    @(negedge clk);
    mem(1, 0, '0);
    #1;
    chk("t4_c3_gnt", {bus_req, bus_we, bus_be}, 6'b11_0011);
    @(negedge clk);
    mem(0, 1, '0);
    #1;
    chk("t4_d_done", {if_done, d_done}, 2'b01);
    @(negedge clk);
    d_we = 0; d_addr = '0; d_w_data = '0; d_w_mask = '0; mem(1, 0, '0);
    #1;
    chk("t4_fetch_addr", bus_addr, 32'h300);
    @(negedge clk);
    mem(0, 1, 32'h0000_0073);
    #1;
    chk("t4_if_data", {if_done, if_data}, {1'b1, 32'h0000_0073});
    @(negedge clk);
    clear_reqs(); mem(0, 0, '0);

    // 5: reset while waiting for a data response
    @(negedge clk);
    d_re = 1; d_addr = 32'h5000; mem(1, 0, '0);
    #1;
    chk("t5_req", bus_req, 1);
    @(negedge clk);
    rst = 1; mem(0, 0, '0);
    #1;
    chk("t5_rst_req", bus_req, 0);
    @(negedge clk);
    mem(0, 1, 32'hBAD0_BAD0);
    #1;
    chk("t5_no_done", {if_done, d_done}, 0);
    chk("t5_no_data", d_r_data, 0);
    @(negedge clk);
    rst = 0; clear_reqs(); mem(0, 0, '0);
    #1;
    chk("t5_outputs_zero", {bus_req, bus_we, bus_addr, bus_wdata, bus_be, if_done, d_done}, 0);
    @(negedge clk);
    if_valid = 1; if_addr = 32'h400; mem(1, 0, '0);
    #1;
    chk("t5_idle_req", {bus_req, bus_addr}, {1'b1, 32'h400});
    @(negedge clk);
    mem(0, 1, 32'h13);
    #1;
    chk("t5_if_done", if_done, 1);
    @(negedge clk);
    clear_reqs(); mem(0, 0, '0);

    // 6: random grant/response delays with a per-port scoreboard
    auto_mode = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      kind    = $urandom_range(0, 2);
      if_pend = (kind != 1);
      d_pend  = (kind != 0);
      d_is_rd = ($urandom_range(0, 1) == 1);
      ia = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      da = {16'h1, 14'($urandom_range(0, 16383)), 2'b00};
      cyc = 0;
      while ((if_pend || d_pend) && cyc < 100) begin
        @(negedge clk);
        if (cyc == 0) begin
          if_valid = if_pend; if_addr = if_pend ? ia : '0;
          d_re = d_pend && d_is_rd; d_we = d_pend && !d_is_rd;
          d_addr = d_pend ? da : '0;
          d_w_data = $urandom; d_w_mask = 4'($urandom_range(1, 15));
        end else begin
          if (!if_pend) if_valid = 0;
          if (!d_pend) begin d_re = 0; d_we = 0; end
        end
        #1;
        chk("rnd_done_excl", {31'h0, if_done & d_done}, 0);
        if (if_done) begin
          chk("rnd_if_expected", {31'h0, if_pend}, 1);
          chk("rnd_if_data", if_data, mem_f(ia));
          if_pend = 0;
        end
        if (d_done) begin
          chk("rnd_d_expected", {31'h0, d_pend}, 1);
          if (d_is_rd) chk("rnd_d_r_data", d_r_data, mem_f(da));
          d_pend = 0;
        end
        cyc++;
      end
      if (if_pend || d_pend) begin
        chk("rnd_timeout", {30'h0, if_pend, d_pend}, 0);
        break;
      end
    end
    @(negedge clk);
    clear_reqs();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
